// File: rtl/sdp_reg_wr_arb.sv
// Round-robin write arbiter in front of a shared enable-gated SDP register.
// Optional grant-hold lock: define SDP_REGARB_LOCK_EN to add the req_lock port.
module sdp_reg_wr_arb #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef SDP_REGARB_LOCK_EN
   input  logic [NUM_REQ-1:0]       req_lock,
`endif
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         reg_d,
   output logic                     reg_en,
   output logic [IDW-1:0]           grant_id,
   output logic                     busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       grant_id_q, grant_id_d;
   logic [WIDTH-1:0]     reg_d_q, reg_d_d;
   logic                 reg_en_q, reg_en_d;
   logic                 busy_q, busy_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;

   logic                 found;
   logic [IDW-1:0]       win_id;
   logic [WIDTH-1:0]     win_data;
   logic                 lock_hold;
   logic [IDW-1:0]       ptr_next;

   // Cyclic search upward from ptr_q; the first valid requester wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      found  = 1'b0;
      win_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            win_id = IDW'(idx);
         end
      end
   end

   assign win_data = req_data[int'(win_id)*WIDTH +: WIDTH];

`ifdef SDP_REGARB_LOCK_EN
   assign lock_hold = req_lock[grant_id_q];
`else
   assign lock_hold = 1'b0;
`endif

   // NUM_REQ need not be a power of two, so the increment wraps explicitly.
   always_comb begin
      if (lock_hold) begin
         ptr_next = grant_id_q;
      end else if (int'(grant_id_q) == NUM_REQ - 1) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_id_q + IDW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_id_d  = grant_id_q;
      reg_d_d     = reg_d_q;
      reg_en_d    = 1'b0;
      busy_d      = 1'b0;
      req_ready_d = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = WRITE;
               grant_id_d  = win_id;
               reg_d_d     = win_data;
               reg_en_d    = 1'b1;
               busy_d      = 1'b1;
               req_ready_d = NUM_REQ'(1) << win_id;
            end
         end
         WRITE: begin
            // WRITE lasts one cycle; the pointer moves as it retires.
            state_d = IDLE;
            ptr_d   = ptr_next;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs; async reset clears the handshake mid-WRITE at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_id_q  <= '0;
         reg_d_q     <= '0;
         reg_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         req_ready_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_id_q  <= grant_id_d;
         reg_d_q     <= reg_d_d;
         reg_en_q    <= reg_en_d;
         busy_q      <= busy_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign req_ready = req_ready_q;
   assign reg_d     = reg_d_q;
   assign reg_en    = reg_en_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sdp_reg_wr_arb.sv
// Directed bench for sdp_reg_wr_arb: vector table plus reset, NUM_REQ=3 and lock sequences.
module tb_sdp_reg_wr_arb;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic [31:0]  reg_d;
   logic         reg_en;
   logic [1:0]   grant_id;
   logic         busy;

   logic [2:0]   req_valid3;
   logic [23:0]  req_data3;
   logic [2:0]   req_ready3;
   logic [7:0]   reg_d3;
   logic         reg_en3;
   logic [1:0]   grant_id3;
   logic         busy3;

`ifdef SDP_REGARB_LOCK_EN
   logic [3:0]   req_lock;
   logic [2:0]   req_lock3;
`endif

   sdp_reg_wr_arb #(.NUM_REQ(4), .WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef SDP_REGARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .reg_d     (reg_d),
      .reg_en    (reg_en),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   sdp_reg_wr_arb #(.NUM_REQ(3), .WIDTH(8)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid3),
      .req_data  (req_data3),
`ifdef SDP_REGARB_LOCK_EN
      .req_lock  (req_lock3),
`endif
      .req_ready (req_ready3),
      .reg_d     (reg_d3),
      .reg_en    (reg_en3),
      .grant_id  (grant_id3),
      .busy      (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic        en;
      logic [3:0]  ready;
      logic [1:0]  gid;
      logic [31:0] d;
      logic        busy;
   } vec_t;

   vec_t vecs[$];
   int   pass_cnt;
   int   total_cnt;

   function automatic logic [31:0] data_of(input int i);
      case (i)
         0:       return 32'h1111_1111;
         1:       return 32'h2222_2222;
         2:       return 32'hDEAD_BEEF;
         default: return 32'h4444_4444;
      endcase
   endfunction

   function automatic void add(input logic [3:0] valid, input logic en, input logic [3:0] ready,
                               input int gid, input logic busy_e);
      vec_t v;
      v.valid = valid;
      v.en    = en;
      v.ready = ready;
      v.gid   = 2'(gid);
      v.d     = data_of(gid);
      v.busy  = busy_e;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_main(input string tag, input logic en, input logic [3:0] ready,
                             input logic [1:0] gid, input logic [31:0] d, input logic busy_e);
      check({tag, ".reg_en"},    64'(reg_en),    64'(en));
      check({tag, ".req_ready"}, 64'(req_ready), 64'(ready));
      check({tag, ".grant_id"},  64'(grant_id),  64'(gid));
      check({tag, ".reg_d"},     64'(reg_d),     64'(d));
      check({tag, ".busy"},      64'(busy),      64'(busy_e));
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      rst        = 1'b1;
      req_valid  = 4'b0000;
      req_valid3 = 3'b000;
      req_data3  = {8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = data_of(i);
`ifdef SDP_REGARB_LOCK_EN
      req_lock   = 4'b0000;
      req_lock3  = 3'b000;
`endif

      #2;
      check_main("reset", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
      #10;
      rst = 1'b0;

      // All-request rotation: 0,1,2,3,0,1,2,3 on alternate cycles.
      for (int i = 0; i < 8; i++) begin
         add(4'b1111, 1'b1, 4'b0001 << (i % 4), i % 4, 1'b1);
         add(4'b1111, 1'b0, 4'b0000, i % 4, 1'b0);
      end
      // Single requester 2, repeat grant every other cycle.
      for (int i = 0; i < 2; i++) begin
         add(4'b0100, 1'b1, 4'b0100, 2, 1'b1);
         add(4'b0100, 1'b0, 4'b0000, 2, 1'b0);
      end
      // ptr=3 after grant to 2: 0 then 1, no idle cycles for 2 and 3.
      add(4'b0011, 1'b1, 4'b0001, 0, 1'b1);
      add(4'b0011, 1'b0, 4'b0000, 0, 1'b0);
      add(4'b0011, 1'b1, 4'b0010, 1, 1'b1);
      add(4'b0000, 1'b0, 4'b0000, 1, 1'b0);
      add(4'b0000, 1'b0, 4'b0000, 1, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         req_valid = vecs[i].valid;
         tick();
         check_main($sformatf("vec%0d", i), vecs[i].en, vecs[i].ready, vecs[i].gid,
                    vecs[i].d, vecs[i].busy);
      end

      // ptr=2 now: request from 3 enters WRITE, then reset lands mid-cycle.
      req_valid = 4'b1000;
      tick();
      check_main("pre_rst", 1'b1, 4'b1000, 2'd3, 32'h4444_4444, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_main("mid_rst", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
      #2;
      rst = 1'b0;
      req_valid = 4'b0000;
      tick();
      check_main("post_rst_idle", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
      // ptr back to 0: requester 0 wins over 1..3.
      req_valid = 4'b1111;
      tick();
      check_main("post_rst_grant", 1'b1, 4'b0001, 2'd0, 32'h1111_1111, 1'b1);
      req_valid = 4'b0000;
      tick();
      check("post_rst_release.reg_en", 64'(reg_en), 64'(0));

      // NUM_REQ=3 build: grants 0,1,2,0, one-hot within 3 bits.
      begin
         logic [1:0] exp3 [4];
         exp3[0] = 2'd0; exp3[1] = 2'd1; exp3[2] = 2'd2; exp3[3] = 2'd0;
         req_valid3 = 3'b111;
         for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("n3_w%0d.grant_id", i), 64'(grant_id3), 64'(exp3[i]));
            check($sformatf("n3_w%0d.req_ready", i), 64'(req_ready3), 64'(3'b001 << exp3[i]));
            check($sformatf("n3_w%0d.reg_en", i), 64'(reg_en3), 64'(1));
            tick();
            check($sformatf("n3_i%0d.reg_en", i), 64'(reg_en3), 64'(0));
         end
         req_valid3 = 3'b000;
      end

`ifdef SDP_REGARB_LOCK_EN
      // Lock on requester 0 for three writes, released during the third.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      req_valid = 4'b0011;
      req_lock  = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) req_lock = 4'b0000;
         check_main($sformatf("lock_w%0d", i), 1'b1, 4'b0001, 2'd0, 32'h1111_1111, 1'b1);
         tick();
         check($sformatf("lock_i%0d.reg_en", i), 64'(reg_en), 64'(0));
      end
      tick();
      check_main("lock_after", 1'b1, 4'b0010, 2'd1, 32'h2222_2222, 1'b1);
      req_valid = 4'b0000;
      tick();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sdp_reg_wr_arb.md
# sdp_reg_wr_arb

Round-robin write arbiter that shares a single enable-gated register between `NUM_REQ` requesters in the SDP datapath. It sits directly in front of an `sdp_enreg`/`sdp_enrstreg` instance and drives that register's `d` and `en` inputs. Each requester uses a valid/ready handshake, and the arbiter serialises accepted writes at most one every two cycles with fair rotation.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `WIDTH`, default 32: data width of the shared register.
- `IDW`, default `$clog2(NUM_REQ)`: width of the grant index; derived, do not override.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_data`  in  NUM_REQ*WIDTH  packed write data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse; a write is consumed when `valid&&ready`.
- `reg_d`  out  WIDTH  data to the shared register's `d` input.
- `reg_en`  out  1  write enable to the shared register's `en` input.
- `grant_id`  out  IDW  index of the current or most recent grantee.
- `busy`  out  1  high while in state WRITE.
- `req_lock`  in  NUM_REQ  grant-hold request. Present only when `SDP_REGARB_LOCK_EN` is defined.

## Operation
- State machine with two states: IDLE and WRITE. Reset state is IDLE.
- Rotation pointer `ptr` is IDW bits wide and resets to 0.
- **IDLE**
  - If no `req_valid` bit is set, remain in IDLE.
  - Otherwise select the first set bit at or after `ptr`, searching cyclically upward and wrapping from NUM_REQ-1 to 0.
  - Register the winner into `grant_id`.
  - Latch the winner's `req_data` slice into `reg_d`.
  - Go to WRITE.
- **WRITE** (always exactly one cycle)
  - `reg_en`=1, `busy`=1, and `req_ready[grant_id]`=1; all other ready bits are 0.
  - Set `ptr` to `grant_id`+1 modulo NUM_REQ. Wrap explicitly; NUM_REQ need not be a power of 2.
  - Go to IDLE.
- **Requester rules**
  - A requester holds `req_valid` and its data stable from assertion until it sees `req_ready`.
  - If a requester drops `req_valid` while in WRITE, the committed write still completes. This is a protocol violation and is not checked.
- **Held outputs**
  - `reg_d` and `grant_id` hold their values in IDLE. They change only on a new grant.
- **Reset mid-operation**
  - `rst` asserted in WRITE aborts immediately.
  - `reg_en` and all `req_ready` bits drop combinationally with reset. No partial handshake is reported.
- **Reset values**: `reg_en`=0, `req_ready`=0, `reg_d`=0, `grant_id`=0, `busy`=0, `ptr`=0, state=IDLE.

## Timing
- Latency:
  - `req_valid` is sampled high in IDLE at cycle N.
  - `reg_en` and `req_ready` are high in cycle N+1.
  - The shared register's `q` updates at the end of N+1.
- Throughput: at most one write per 2 cycles. WRITE is never followed directly by WRITE.
- Fairness bound: a continuously asserting requester is served within `2*NUM_REQ` cycles of assertion.
- Outputs are registered and there are no combinational paths from `req_*` to outputs.
  - Exception: reset clears outputs asynchronously.
- A new request arriving during WRITE is evaluated in the following IDLE cycle against the updated `ptr`.

## Configuration
- Macro: `SDP_REGARB_LOCK_EN`.
- **Defined**
  - The `req_lock` port exists.
  - In WRITE, if `req_lock[grant_id]`=1, `ptr` is set to `grant_id` instead of `grant_id`+1.
  - The same requester therefore wins the next IDLE cycle if it is still valid, which allows atomic multi-word sequences.
  - When the lock is released, rotation resumes from `grant_id`+1.
- **Undefined**
  - The `req_lock` port is absent.
  - Pure round-robin, exactly as described above.

## Test plan
- Reset check:
  - Stimulus: assert `rst` asynchronously mid-cycle while in WRITE.
  - Required response: `reg_en`, `req_ready` and `busy` go to 0 before the next edge; then `ptr`=0, `grant_id`=0 and `reg_d`=0.
- Single requester:
  - Stimulus: `req_valid`=4'b0100 with data 0xDEADBEEF, held.
  - Required response: in the next cycle, `reg_en`=1, `req_ready`=4'b0100, `grant_id`=2 and `reg_d`=0xDEADBEEF. A repeat grant follows every 2 cycles.
- All-request rotation:
  - Stimulus: `req_valid`=4'b1111 held for 16 cycles.
  - Required response: grants in the order 0,1,2,3,0,1,2,3 on alternate cycles, each `req_ready` one-hot.
- Wrap with gap:
  - Stimulus: `ptr`=3 (after a grant to requester 2), then `req_valid`=4'b0011.
  - Required response: grant to 0 then 1; requesters 2 and 3 are skipped without idle cycles.
- NUM_REQ=3 build:
  - Stimulus: all three requesters valid.
  - Required response: grant sequence 0,1,2,0; `ptr` never reaches 3.
- Lock (with `SDP_REGARB_LOCK_EN`):
  - Stimulus: `req_valid`=4'b0011 with `req_lock[0]`=1 held for 3 writes.
  - Required response: requester 0 receives 3 consecutive grants; after lock release, requester 1 is granted next.
